// File: rtl/sopc_top_pio_edge_irq.sv
// Pin monitor for the bidirectional PIO: 2-flop sync, tick-sampled debounce filter, edge capture, maskable irq.
// Avalon reads have 1-cycle latency. irq is registered and follows a capture bit by 1 clk. There is no backpressure.
module sopc_top_pio_edge_irq #(
  parameter int          WIDTH        = 32,
  parameter logic [15:0] DEBOUNCE_DIV = 16'd999,
  parameter int          FILTER_LEN   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q [FILTER_LEN];
  logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, esel_q, esel_d, any_q, any_d;
  logic [15:0]      div_q, div_d, presc_q, presc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             primed_q, primed_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             tick, wr;
  logic [WIDTH-1:0] wdat, all_one, all_zero, rise, fall, detected, w1c;

  always_comb begin
    tick     = (presc_q == 16'd0);
    wr       = chipselect & ~write_n;
    wdat     = writedata[WIDTH-1:0];
    all_one  = '1;
    all_zero = '1;
    for (int i = 0; i < FILTER_LEN; i++) begin
      all_one  = all_one & filt_q[i];
      all_zero = all_zero & ~filt_q[i];
    end
    deb_d = (deb_q | all_one) & ~all_zero;
    // Until primed, the history register tracks the incoming value so the
    // initial fill of the filter never presents as an edge.
    deb_prev_d = primed_q ? deb_q : deb_d;
    rise       = deb_q & ~deb_prev_q;
    fall       = ~deb_q & deb_prev_q;
    detected   = (any_q & (rise | fall)) | (~any_q & ((esel_q & fall) | (~esel_q & rise)));
    w1c        = (wr && address == 3'd3) ? wdat : '0;
    cap_d      = (cap_q & ~w1c) | (detected & {WIDTH{primed_q}});
    irq_d      = |(cap_q & mask_q);

    mask_d  = mask_q;
    esel_d  = esel_q;
    any_d   = any_q;
    div_d   = div_q;
    presc_d = tick ? div_q : presc_q - 16'd1;
    if (wr) begin
      case (address)
        3'd2: mask_d = wdat;
        3'd4: esel_d = wdat;
        3'd5: any_d  = wdat;
        3'd6: begin
          div_d   = writedata[15:0];
          presc_d = writedata[15:0];
        end
        default: ;
      endcase
    end

    fill_d = fill_q;
    if (tick && fill_q != FW'(FILTER_LEN)) fill_d = fill_q + FW'(1);
    primed_d = primed_q | (fill_q == FW'(FILTER_LEN));

    rdata_d = '0;
    case (address)
      3'd0: rdata_d[WIDTH-1:0] = deb_q;
      3'd1: rdata_d[WIDTH-1:0] = sync2_q;
      3'd2: rdata_d[WIDTH-1:0] = mask_q;
      3'd3: rdata_d[WIDTH-1:0] = cap_q;
      3'd4: rdata_d[WIDTH-1:0] = esel_q;
      3'd5: rdata_d[WIDTH-1:0] = any_q;
      3'd6: rdata_d[15:0]      = div_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      for (int i = 0; i < FILTER_LEN; i++) filt_q[i] <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      esel_q     <= '0;
      any_q      <= '0;
      div_q      <= DEBOUNCE_DIV;
      presc_q    <= DEBOUNCE_DIV;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      if (tick) begin
        filt_q[0] <= sync2_q;
        for (int i = 1; i < FILTER_LEN; i++) filt_q[i] <= filt_q[i-1];
      end
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      esel_q     <= esel_d;
      any_q      <= any_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      fill_q     <= fill_d;
      primed_q   <= primed_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sopc_top_pio_edge_irq.sv
// Scenario bench for the PIO edge/irq monitor; expected read data queued at stimulus time.
module tb_sopc_top_pio_edge_irq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_port;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  sopc_top_pio_edge_irq dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    step(1);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    logic        irq_seen;
    logic [2:0]  ra [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [31:0] re [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    reset_n = 1'b0; in_port = 32'hFFFF_FFFF; address = 3'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    step(3);
    vectors++;
    if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", readdata); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    step(4);
    bus_write(3'd6, 32'h0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    irq_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (irq !== 1'b0) irq_seen = 1'b1;
    end
    vectors++;
    if (irq_seen) begin miscompares++; $display("FAIL prime_irq got 1 want 0"); end
    for (int i = 0; i < 6; i++) exp_q.push_back(re[i]);
    for (int i = 0; i < 6; i++) begin
      bus_read(ra[i], got);
      exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL prime_rd addr%0d got %h want %h", ra[i], got, exp); end
    end
  endtask

  task automatic test_rise();
    logic [31:0] got, exp;
    int first_deb, first_irq;
    in_port = 32'h0;
    step(12);
    exp_q.push_back(32'h0); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fall_ignored got %h want %h", got, exp); end
    bus_write(3'd2, 32'h20);
    address = 3'd0; in_port = 32'h20;
    first_deb = 0; first_irq = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1);
      if (readdata[5] && first_deb == 0) first_deb = n;
      if (irq && first_irq == 0) first_irq = n;
    end
    vectors++;
    if (first_deb == 0 || first_deb > 7) begin miscompares++; $display("FAIL rise_deb_latency got %0d want 1..7", first_deb); end
    vectors++;
    if (first_irq != first_deb + 1) begin miscompares++; $display("FAIL rise_irq_latency got %0d want %0d", first_irq, first_deb + 1); end
    exp_q.push_back(32'h20); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rise_cap got %h want %h", got, exp); end
    bus_write(3'd2, 32'h0);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL mask_irq_reg got %b want 1", irq); end
    step(1);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL mask_irq_off got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] got, exp;
    bus_write(3'd6, 32'd3);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'hA0; step(4);
    in_port = 32'h20; step(24);
    exp_q.push_back(32'h20); exp_q.push_back(32'h0);
    bus_read(3'd0, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL glitch_deb got %h want %h", got, exp); end
    bus_read(3'd3, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL glitch_cap got %h want %h", got, exp); end
    in_port = 32'hA0; step(24);
    exp_q.push_back(32'hA0); exp_q.push_back(32'h80);
    bus_read(3'd0, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pulse_deb got %h want %h", got, exp); end
    bus_read(3'd3, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pulse_cap got %h want %h", got, exp); end
    in_port = 32'h20; step(24);
    bus_write(3'd6, 32'd0); step(10);
    bus_write(3'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_edge_sel();
    logic [31:0] got, exp;
    bus_write(3'd4, 32'h1);
    bus_write(3'd5, 32'h2);
    in_port = 32'h23; step(10);
    exp_q.push_back(32'h2); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL esel_rise_cap got %h want %h", got, exp); end
    bus_write(3'd3, 32'h3);
    exp_q.push_back(32'h0); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL esel_clear got %h want %h", got, exp); end
    in_port = 32'h20; step(10);
    exp_q.push_back(32'h3); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL esel_fall_cap got %h want %h", got, exp); end
    bus_write(3'd3, 32'h3);
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h0);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] got, exp;
    in_port = 32'h0; step(10);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'h20;
    step(6);
    bus_write(3'd3, 32'h20);
    exp_q.push_back(32'h20); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL w1c_collide got %h want %h", got, exp); end
    bus_write(3'd2, 32'h20);
    bus_read(3'd0, got);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL w1c_irq_on got %b want 1", irq); end
    bus_write(3'd3, 32'h20);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL w1c_irq_hold got %b want 1", irq); end
    step(1);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq_drop got %b want 0", irq); end
    exp_q.push_back(32'h0); bus_read(3'd3, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL w1c_cleared got %h want %h", got, exp); end
  endtask

  task automatic test_div_reset();
    logic [31:0] got, exp;
    logic        want_tick;
    bus_write(3'd2, 32'hFFFF_FFFF);
    in_port = 32'h220; step(12);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL bit9_irq got %b want 1", irq); end
    bus_write(3'd6, 32'd100); step(7);
    bus_write(3'd6, 32'd5);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      want_tick = (k == 5 || k == 11);
      vectors++;
      if (dut.tick !== want_tick) begin miscompares++; $display("FAIL div_tick k=%0d got %b want %b", k, dut.tick, want_tick); end
    end
    exp_q.push_back(32'h5); bus_read(3'd6, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL div_read got %h want %h", got, exp); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got rd=%h irq=%b want 0/0", readdata, irq);
    end
    step(2);
    reset_n = 1'b1;
    step(2);
    exp_q.push_back(32'h3E7); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_read(3'd6, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_div got %h want %h", got, exp); end
    bus_read(3'd3, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_cap got %h want %h", got, exp); end
    bus_read(3'd2, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_mask got %h want %h", got, exp); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_edge_sel();
    test_w1c_collision();
    test_div_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
